frame_reader: RTL
=================

// Module: frame_reader
// PURPOSE
// Streams a stored image out of the frame-buffer BRAM in step with the VGA raster. It places an
// H_SIZE x V_SIZE image at a programmable offset inside the visible area and fills the rest with a
// border colour. It double-buffers between two BRAM banks, swapping only at frame boundaries.
// It sits between the frame-buffer BRAM read port and the VGA colour/DAC stage.
// PARAMETERS
// H_SIZE     607  image width in pixels
// V_SIZE     455  image height in lines
// H_OFFSET   16   first image column within the visible area
// V_OFFSET   12   first image line within the visible area
// H_ACTIVE   640  visible columns; H_OFFSET+H_SIZE <= H_ACTIVE (checked at elaboration)
// V_ACTIVE   480  visible lines; V_OFFSET+V_SIZE <= V_ACTIVE (checked at elaboration)
// COLOR_W    6    bits per colour channel; pixel word = 3*COLOR_W
// ADDR_W     19   per-bank address width; 2**ADDR_W >= H_SIZE*V_SIZE
// PORTS
// clk          in   1          system clock; must run at least RD_LAT+3 cycles per pixel_clk period
// reset        in   1          synchronous, active-high
// pixel_clk    in   1          VGA pixel clock (asynchronous); sampled, never used as a clock
// x            in   10         VGA horizontal count 0..H_TOTAL-1
// y            in   10         VGA vertical count 0..V_TOTAL-1
// r_data       in   3*COLOR_W  BRAM read data; valid RD_LAT(<=2) clk after r_address
// bank_req     in   1          1-clk pulse: swap the displayed bank at the next frame start
// border_rgb   in   3*COLOR_W  colour for visible pixels outside the image
// r_address    out  ADDR_W+1   {bank, pixel address}
// raw_rgb      out  3*COLOR_W  registered pixel colour
// bank_active  out  1          bank currently displayed
// frame_start  out  1          1-clk pulse at each frame-start tick
// frame_err    out  1          sticky flag: frame ended with the pixel address not at 0
// BEHAVIOUR
// - Reset: state=SYNC, r_address=0, raw_rgb=0, bank_active=0, frame_start=0, frame_err=0, no pending swap.
// - tick: 1-clk pulse, 2 clk after the rising edge of pixel_clk (2-FF synchroniser + edge detect).
//   x and y are sampled only on tick.
// - Frame-start tick (FS): tick with x==H_TOTAL-1 and y==V_TOTAL-1.
//   On FS, in either state: frame_start=1 that clk, address forced to 0, state goes to RUN.
//   If a swap is pending: bank_active toggles and the pending flag clears.
//   If state was RUN and address !=0: frame_err is set.
// - SYNC: raw_rgb held at 0; the address does not advance; wait for FS.
// - RUN, on each tick, classified by (x,y):
//   image pixel: H_OFFSET<=x<H_OFFSET+H_SIZE and V_OFFSET<=y<V_OFFSET+V_SIZE.
//     raw_rgb<=r_data; address<=address+1.
//     At H_SIZE*V_SIZE-1 the address wraps to 0 and does not advance again until FS.
//   visible, non-image: raw_rgb<=border_rgb.
//   blanking (x>=H_ACTIVE or y>=V_ACTIVE): raw_rgb<=0.
// - Latency: raw_rgb updates 1 clk after tick. r_address always holds the next image pixel,
//   so the BRAM data is settled before the next tick.
// - bank_req: latched as pending. bank_req and FS in the same clk swap at that FS.
//   A repeated request while one is pending is absorbed (one swap only).
// - Between ticks, every output except the pulse outputs holds its value.
// - Reset mid-frame returns the block to SYNC; it resumes at the next FS.
// STRUCTURE
// - Package frame_reader_pkg: H_TOTAL=800 and V_TOTAL=525; state enum {SYNC, RUN};
//   typedef rgb_t as logic [3*COLOR_W-1:0].
// - Sub-module pixel_tick_gen: synchroniser plus rising-edge detector producing tick.
//   Reset clears all of its flops.
// - Top level: address counter, window compare, bank/pending logic, raw_rgb register.
// TESTING (H_SIZE=4, V_SIZE=3, H_OFFSET=2, V_OFFSET=1, pixel_clk=clk/4, BRAM model with
// r_data = address, RD_LAT=1)
// 1. Reset, then the first FS: frame_start pulses once; r_address=0; raw_rgb=0 before FS.
// 2. Line y=1, x=2..5: raw_rgb=0,1,2,3. x=0,1,6: raw_rgb=border_rgb. x=640: raw_rgb=0.
//    After y=3: r_address wrapped to 0; frame_err stays 0 at the next FS.
// 3. bank_req pulse mid-frame: bank_active and r_address[ADDR_W] flip only at the next FS.
//    A second bank_req in the same frame causes no extra swap.
// 4. bank_req in the same clk as FS: swap at that FS.
// 5. Skip 3 ticks inside the image, then FS: frame_err=1 and stays set;
//    r_address=0; the next frame displays correctly.
// 6. Assert reset at y=2, x=3: outputs go to their reset values; raw_rgb=0 until the next FS,
//    then normal output from pixel 0.

Source files
------------

// File: rtl/frame_reader_pkg.sv
// Shared definitions for the frame reader.
// Holds the raster totals, the reader state encoding and the default pixel type.
package frame_reader_pkg;

  // Full raster size, visible plus blanking.
  localparam int H_TOTAL     = 800;
  localparam int V_TOTAL     = 525;

  // Default colour depth per channel.
  localparam int DEF_COLOR_W = 6;

  typedef enum logic [0:0] {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [3*DEF_COLOR_W-1:0] rgb_t;

endpackage

// File: rtl/frame_reader_pixel_tick_gen.sv
// pixel_tick_gen: brings the asynchronous VGA pixel clock into the clk domain
// and produces a one-clk tick after each of its rising edges.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high; clears all flops
//   pixel_clk in   VGA pixel clock, sampled as data
//   tick      out  1-clk pulse, 2 clk after a pixel_clk rising edge
module pixel_tick_gen (
  input  logic clk,
  input  logic reset,
  input  logic pixel_clk,
  output logic tick
);

  // sync[0], sync[1] form the synchroniser; sync[2] is the edge-detect history.
  logic [2:0] sync;

  // Shift the sampled pixel clock through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 3'b000;
    end else begin
      sync <= {sync[1:0], pixel_clk};
    end
  end

  assign tick = sync[1] & ~sync[2];

endmodule

// File: rtl/frame_reader.sv
// frame_reader: streams a stored image from a double-banked frame-buffer BRAM
// in step with the VGA raster, placing it at a fixed offset inside the visible
// area and filling the remainder with a border colour.
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   pixel_clk     VGA pixel clock, sampled only
//   x, y          VGA raster counters
//   r_data        BRAM read data
//   bank_req      pulse: swap the displayed bank at the next frame start
//   border_rgb    colour for visible pixels outside the image
//   r_address     {bank, pixel address} to the BRAM
//   raw_rgb       registered pixel colour
//   bank_active   bank currently displayed
//   frame_start   1-clk pulse on each frame-start tick
//   frame_err     sticky: a frame ended with the pixel address not at 0
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int H_SIZE   = 607,
  parameter int V_SIZE   = 455,
  parameter int H_OFFSET = 16,
  parameter int V_OFFSET = 12,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int ADDR_W   = 19
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pixel_clk,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic [3*COLOR_W-1:0] r_data,
  input  logic                 bank_req,
  input  logic [3*COLOR_W-1:0] border_rgb,
  output logic [ADDR_W:0]      r_address,
  output logic [3*COLOR_W-1:0] raw_rgb,
  output logic                 bank_active,
  output logic                 frame_start,
  output logic                 frame_err
);

  localparam logic [9:0] X_FIRST = 10'(H_OFFSET);
  localparam logic [9:0] X_END   = 10'(H_OFFSET + H_SIZE);
  localparam logic [9:0] Y_FIRST = 10'(V_OFFSET);
  localparam logic [9:0] Y_END   = 10'(V_OFFSET + V_SIZE);
  localparam logic [9:0] X_VIS   = 10'(H_ACTIVE);
  localparam logic [9:0] Y_VIS   = 10'(V_ACTIVE);
  localparam logic [9:0] X_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST  = 10'(V_TOTAL - 1);

  localparam logic [ADDR_W-1:0]    ADDR_LAST = ADDR_W'(H_SIZE * V_SIZE - 1);
  localparam logic [ADDR_W-1:0]    ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0]    ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [3*COLOR_W-1:0] RGB_ZERO  = {(3*COLOR_W){1'b0}};

  if (H_OFFSET + H_SIZE > H_ACTIVE) begin : g_h_fit_check
    $error("frame_reader: image does not fit horizontally in the visible area");
  end
  if (V_OFFSET + V_SIZE > V_ACTIVE) begin : g_v_fit_check
    $error("frame_reader: image does not fit vertically in the visible area");
  end
  if ((64'd1 << ADDR_W) < 64'(H_SIZE * V_SIZE)) begin : g_addr_fit_check
    $error("frame_reader: ADDR_W too small for the image");
  end

  logic                 tick;
  state_t               state;
  state_t               state_next;
  logic [ADDR_W-1:0]    addr;
  logic [ADDR_W-1:0]    addr_next;
  logic                 addr_hold;
  logic                 addr_hold_next;
  logic [3*COLOR_W-1:0] rgb_next;
  logic                 pending;
  logic                 fs;
  logic                 in_image;
  logic                 visible;

  pixel_tick_gen u_tick (
    .clk       (clk),
    .reset     (reset),
    .pixel_clk (pixel_clk),
    .tick      (tick)
  );

  assign fs       = tick && (x == X_LAST) && (y == Y_LAST);
  assign in_image = (x >= X_FIRST) && (x < X_END) && (y >= Y_FIRST) && (y < Y_END);
  assign visible  = (x < X_VIS) && (y < Y_VIS);

  assign r_address = {bank_active, addr};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SYNC;
    end else begin
      state <= state_next;
    end
  end

  // Next state: any frame-start tick puts the reader in RUN.
  always_comb begin
    state_next = state;
    case (state)
      SYNC: begin
        if (fs) begin
          state_next = RUN;
        end else begin
          state_next = SYNC;
        end
      end
      RUN:     state_next = RUN;
      default: state_next = SYNC;
    endcase
  end

  // Output decode: next colour and address for this tick.
  always_comb begin
    rgb_next       = raw_rgb;
    addr_next      = addr;
    addr_hold_next = addr_hold;
    if (fs) begin
      // The frame-start pixel sits in blanking, so the colour is black.
      rgb_next       = RGB_ZERO;
      addr_next      = ADDR_ZERO;
      addr_hold_next = 1'b0;
    end else if (tick && (state == RUN)) begin
      if (in_image) begin
        rgb_next = r_data;
        // After the last image pixel the address parks at 0 until the next frame.
        if (addr_hold) begin
          addr_next = addr;
        end else if (addr == ADDR_LAST) begin
          addr_next      = ADDR_ZERO;
          addr_hold_next = 1'b1;
        end else begin
          addr_next = addr + ADDR_ONE;
        end
      end else if (visible) begin
        rgb_next = border_rgb;
      end else begin
        rgb_next = RGB_ZERO;
      end
    end else begin
      rgb_next = raw_rgb;
    end
  end

  // Datapath registers: colour, pixel address and its park flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      raw_rgb   <= RGB_ZERO;
      addr      <= ADDR_ZERO;
      addr_hold <= 1'b0;
    end else begin
      raw_rgb   <= rgb_next;
      addr      <= addr_next;
      addr_hold <= addr_hold_next;
    end
  end

  // Bank swap, frame-start pulse and frame error tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_active <= 1'b0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_start <= fs;
      if (fs) begin
        // A request arriving on the frame-start clk is honoured immediately.
        bank_active <= bank_active ^ (pending | bank_req);
        pending     <= 1'b0;
        if ((state == RUN) && (addr != ADDR_ZERO)) begin
          frame_err <= 1'b1;
        end else begin
          frame_err <= frame_err;
        end
      end else if (bank_req) begin
        pending <= 1'b1;
      end else begin
        pending <= pending;
      end
    end
  end

endmodule
